// File: rtl/lifting_predict_stage.sv
// Predict step of the integer lifting DWT: pairs even/odd samples of a row and
// emits (approximation, detail). MODE 0 = Haar, MODE 1 = LeGall 5/3 with symmetric extension.
module lifting_predict_stage #(
  parameter int DATA_W = 16,
  parameter int MODE   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_approx,
  output logic [DATA_W:0]     m_detail,
  output logic                m_last
);

  // state  | meaning
  // S_EVEN | waiting for the even sample of a new pair
  // S_ODD  | even held in e_q, waiting for the odd sample
  // S_NEXT | 5/3 only: e_q and o_q held, waiting for the next even to form the predictor
  // S_TAIL | 5/3 odd-length row: final lone even in e_q, emit it once the output is free
  typedef enum logic [1:0] {S_EVEN, S_ODD, S_NEXT, S_TAIL} state_t;

  localparam int DW = DATA_W + 1;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   e_q, e_d;
  logic [DATA_W-1:0]   o_q, o_d;
  logic                rdy_en_q, rdy_en_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_approx_q, m_approx_d;
  logic [DATA_W:0]     m_detail_q, m_detail_d;
  logic                m_last_q, m_last_d;

  logic                out_free;
  logic                s_ready_int;
  logic                acc;
  logic                load;
  logic [DATA_W-1:0]   ld_a;
  logic [DATA_W:0]     ld_d;
  logic                ld_l;
  logic signed [DW-1:0] x_ext, e_ext, o_ext, avg;

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    o_d        = o_q;
    rdy_en_d   = 1'b1;
    m_valid_d  = m_valid_q;
    m_approx_d = m_approx_q;
    m_detail_d = m_detail_q;
    m_last_d   = m_last_q;
    load       = 1'b0;
    ld_a       = '0;
    ld_d       = '0;
    ld_l       = 1'b0;

    out_free    = !m_valid_q || m_ready;
    s_ready_int = rdy_en_q && out_free && (state_q != S_TAIL);
    acc         = s_valid && s_ready_int;

    // Sign-extend one bit so neither the sum nor the difference can wrap
    x_ext = $signed({s_data[DATA_W-1], s_data});
    e_ext = $signed({e_q[DATA_W-1], e_q});
    o_ext = $signed({o_q[DATA_W-1], o_q});
    avg   = (e_ext + x_ext) >>> 1;

    case (state_q)
      S_EVEN: begin
        if (acc) begin
          e_d = s_data;
          if (s_last) begin
            load = 1'b1;
            ld_a = s_data;
            ld_l = 1'b1;
          end else begin
            state_d = S_ODD;
          end
        end
      end
      S_ODD: begin
        if (acc) begin
          // A 5/3 row ending on an odd mirrors x[L]=x[L-2], so the predictor is e itself
          if (MODE == 0 || s_last) begin
            load    = 1'b1;
            ld_a    = e_q;
            ld_d    = x_ext - e_ext;
            ld_l    = s_last;
            state_d = S_EVEN;
          end else begin
            o_d     = s_data;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (acc) begin
          load    = 1'b1;
          ld_a    = e_q;
          ld_d    = o_ext - avg;
          e_d     = s_data;
          state_d = s_last ? S_TAIL : S_ODD;
        end
      end
      S_TAIL: begin
        if (out_free) begin
          load    = 1'b1;
          ld_a    = e_q;
          ld_l    = 1'b1;
          state_d = S_EVEN;
        end
      end
      default: state_d = S_EVEN;
    endcase

    if (load) begin
      m_valid_d  = 1'b1;
      m_approx_d = ld_a;
      m_detail_d = ld_d;
      m_last_d   = ld_l;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EVEN;
      e_q        <= '0;
      o_q        <= '0;
      rdy_en_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_approx_q <= '0;
      m_detail_q <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      o_q        <= o_d;
      rdy_en_q   <= rdy_en_d;
      m_valid_q  <= m_valid_d;
      m_approx_q <= m_approx_d;
      m_detail_q <= m_detail_d;
      m_last_q   <= m_last_d;
    end
  end

  assign s_ready  = s_ready_int;
  assign m_valid  = m_valid_q;
  assign m_approx = m_approx_q;
  assign m_detail = m_detail_q;
  assign m_last   = m_last_q;

endmodule
